// File: rtl/cpu_bus_responder.sv
// Memory-mapped register bank on the CPU external bus: decodes a word window,
// inserts programmable wait states and acknowledges with a one-cycle ready pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a rising request strobe that hits the window
// S_WAIT | request latched, counting down wait states
// S_ACK  | ready pulse is high this cycle, returning to idle next
module cpu_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_FE00,
    parameter int          ADDR_WORDS  = 16,
    parameter int          WAIT_STATES = 2
) (
    input  logic        i_cpu_clk,
    input  logic        i_rst,
    input  logic        i_bus_clk,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_bus_data,
    output logic        o_bus_data_ready,
    output logic        o_overrun
);

    localparam int IW = $clog2(ADDR_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state_q;
    logic              strb_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [IW-1:0]     idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       regs_q [ADDR_WORDS];
    logic [31:0]       rdata_q;
    logic              rdy_q;
    logic              ovr_q;

    logic [31:0]       offset;
    logic              hit;
    logic              req_edge;

    // Unsigned wrap of the subtraction pushes below-base addresses far out of range.
    assign offset   = i_bus_addr - BASE_ADDR;
    assign hit      = offset < 32'(ADDR_WORDS);
    assign req_edge = i_bus_clk & ~strb_q;

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            strb_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < ADDR_WORDS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            strb_q <= i_bus_clk;
            case (state_q)
                S_IDLE: begin
                    if (req_edge && hit) begin
                        we_q    <= i_bus_we;
                        idx_q   <= offset[IW-1:0];
                        wdata_q <= i_bus_data;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (req_edge) begin
                        ovr_q <= 1'b1;
                    end
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (we_q) begin
                            regs_q[idx_q] <= wdata_q;
                        end else begin
                            rdata_q <= regs_q[idx_q];
                        end
                        rdy_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (req_edge) begin
                        ovr_q <= 1'b1;
                    end
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_bus_data       = rdata_q;
    assign o_bus_data_ready = rdy_q;
    assign o_overrun        = ovr_q;

endmodule
